// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared coin encodings, values and FSM state type
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    WAIT_RELEASE
  } coin_state_e;

  // Bit order of the synchronised sensor vector: {nickle, dime, quarter}
  localparam logic [2:0] COIN_NICKLE  = 3'b100;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b001;

  localparam int NICKLE_CENTS  = 5;
  localparam int DIME_CENTS    = 10;
  localparam int QUARTER_CENTS = 25;

  function automatic logic coin_is_single(input logic [2:0] p);
    return (p == COIN_NICKLE) || (p == COIN_DIME) || (p == COIN_QUARTER);
  endfunction

  function automatic int coin_cents(input logic [2:0] p);
    case (p)
      COIN_NICKLE:  return NICKLE_CENTS;
      COIN_DIME:    return DIME_CENTS;
      COIN_QUARTER: return QUARTER_CENTS;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - raw sensor inputs and clean coin pulse outputs
interface coin_acceptor_if;
  logic nickle_in;
  logic dime_in;
  logic quarter_in;
  logic accept_en;
  logic nickle;
  logic dime;
  logic quarter;
  logic coin_reject;
  logic busy;

  modport slave (
    input  nickle_in, dime_in, quarter_in, accept_en,
    output nickle, dime, quarter, coin_reject, busy
  );

  modport master (
    output nickle_in, dime_in, quarter_in, accept_en,
    input  nickle, dime, quarter, coin_reject, busy
  );
endinterface

// File: rtl/coin_sync.sv
// rtl/coin_sync.sv - 3-bit two-flop synchroniser for the raw coin sensors
module coin_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw,
  output logic [2:0] s
);
  logic [2:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      s    <= '0;
    end else begin
      meta <= raw;
      s    <= meta;
    end
  end
endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounces coin sensors into single-cycle accept/reject pulses
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  coin_acceptor_if.slave bus
);
  import coin_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES);

  logic [2:0]    s;
  coin_state_e   state, state_n;
  logic [2:0]    pat, pat_n;
  logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n;
  logic [3:0]    pulse, pulse_n;  // {nickle, dime, quarter, coin_reject}

  coin_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({bus.nickle_in, bus.dime_in, bus.quarter_in}),
    .s     (s)
  );

  // Reset lands in WAIT_RELEASE so a coin held through reset is never credited
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_RELEASE;
      pat   <= '0;
      cnt   <= '0;
      rcnt  <= '0;
      pulse <= '0;
    end else begin
      state <= state_n;
      pat   <= pat_n;
      cnt   <= cnt_n;
      rcnt  <= rcnt_n;
      pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    pat_n   = pat;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    pulse_n = '0;
    case (state)
      IDLE: begin
        if (s != '0) begin
          pat_n   = s;
          cnt_n   = CW'(1);
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s == '0) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (s != pat) begin
          pat_n = s;
          cnt_n = CW'(1);
        end else if (cnt == CNT_LAST) begin
          cnt_n   = CNT_TERM;
          rcnt_n  = '0;
          state_n = WAIT_RELEASE;
          pulse_n = (coin_is_single(pat) && bus.accept_en) ? {pat, 1'b0} : 4'b0001;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (s != '0) begin
          rcnt_n = '0;
        end else if (rcnt == CNT_LAST) begin
          rcnt_n  = CNT_TERM;
          state_n = IDLE;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.nickle      = pulse[3];
  assign bus.dime        = pulse[2];
  assign bus.quarter     = pulse[1];
  assign bus.coin_reject = pulse[0];
  assign bus.busy        = (state != IDLE);
endmodule
